seq_mult_16_bit: RTL



---
 rtl/seq_mult_16_bit_pkg.sv | 11 +
 rtl/full_adder_16_bit.sv | 22 ++
 rtl/seq_mult_16_bit.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_mult_16_bit_pkg.sv
// Shared constants for the 16x16 shift-and-add multiplier.
// State encodings are plain constants so older netlists keep the same values.
package seq_mult_16_bit_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int ITER = 16;

endpackage

// File: rtl/full_adder_16_bit.sv
// 16-bit ripple-carry adder used by the multiplier's add step.
module full_adder_16_bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic cy;

   always_comb begin
      sum = '0;
      cy  = cin;
      for (int i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ cy;
         cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      cout = cy;
   end

endmodule

// File: rtl/seq_mult_16_bit.sv
// Unsigned 16x16->32 sequential shift-and-add multiplier, one partial product
// per clock through the ripple adder; start/busy/done handshake, 17 cycles per op.
module seq_mult_16_bit
   import seq_mult_16_bit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // The adder instance is fixed at 16 bits, so no other width can work.
   generate
      if (WIDTH != 16) begin : g_bad_width
         $error("seq_mult_16_bit: WIDTH must be 16");
      end
      if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
         $error("seq_mult_16_bit: CNT_W too narrow for WIDTH");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] p_hi;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] nxt_p_hi;
   logic [WIDTH-1:0] nxt_q;

   full_adder_16_bit u_add (
      .a    (p_hi),
      .b    (m),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // Carry-out lands in the accumulator MSB so large products stay exact.
   always_comb begin
      nxt_p_hi = p_hi;
      nxt_q    = q;
      if (q[0]) {nxt_p_hi, nxt_q} = {cout, sum, q[WIDTH-1:1]};
      else      {nxt_p_hi, nxt_q} = {1'b0, p_hi, q[WIDTH-1:1]};
   end

   assign busy = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         m       <= '0;
         p_hi    <= '0;
         q       <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  m     <= a;
                  q     <= b;
                  p_hi  <= '0;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               p_hi <= nxt_p_hi;
               q    <= nxt_q;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(ITER - 1)) begin
                  product <= {nxt_p_hi, nxt_q};
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
